rc4_stream_core: RTL and testbench
==================================

// Module: rc4_stream_core
// PURPOSE
//   Parametrised RC4 cipher engine, successor to the fixed 32-bit-key rc4 core.
//   Accepts keys of 1..KEY_BYTES_MAX bytes and supports RC4-drop[N] (discards the first N keystream bytes).
//   Encrypts/decrypts a byte stream via valid/ready handshakes: out = in ^ keystream.
//   Sits between the host key register block and the byte datapath.
// PARAMETERS
//   KEY_BYTES_MAX  16  max key length in bytes; key bus width = 8*KEY_BYTES_MAX
//   DROP_N         0   keystream bytes discarded after KSA, before the first output (0..65535)
// PORTS
//   clk        in   1      sole clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin INIT+KSA with current key/key_len (single-cycle strobe)
//   key        in   8*KBM  key byte k = key[8k+7:8k]; byte 0 is in the LSBs
//   key_len    in   8      key length in bytes; legal range 1..KEY_BYTES_MAX
//   busy       out  1      high in INIT/KSA/DROP
//   ready      out  1      high in PRGA (keystream available)
//   err        out  1      one-cycle pulse: start rejected because key_len is illegal
//   in_valid   in   1      input byte valid
//   in_ready   out  1      input byte accepted when in_valid & in_ready
//   in_data    in   8      plaintext/ciphertext byte
//   in_last    in   1      marks final byte of a packet
//   out_valid  out  1      output byte valid; held until out_ready
//   out_ready  in   1      downstream accept
//   out_data   out  8      in_data ^ keystream byte
//   out_last   out  1      in_last of the corresponding input byte
// BEHAVIOUR
//   Reset: state=IDLE, i=j=0, all outputs 0 (busy, ready, err, in_ready, out_valid, out_data, out_last).
//     S-box contents undefined until INIT runs. rst mid-operation returns to IDLE next edge and drops any pending output.
//   FSM states: IDLE -> INIT -> KSA -> DROP -> PRGA.
//     DROP is skipped when DROP_N=0.
//   start is accepted in IDLE, or in PRGA when out_valid=0; it is ignored otherwise (busy, or output pending).
//     key and key_len are latched on the accepting edge.
//     If key_len==0 or key_len>KEY_BYTES_MAX: err pulses, state stays/returns to IDLE.
//   INIT: 256 cycles, S[c]=c for c=0..255.
//   KSA: 256 iterations x 2 cycles, i=0..255, j starts at 0.
//     Phase A: j <= j + S[i] + K[i mod key_len].
//     Phase B: swap S[i], S[j]; i <= i+1.
//     i mod key_len is kept as a wrapping counter (no divider).
//   DROP/PRGA step, 2 cycles, i=j=0 on entry.
//     Phase A: i <= i+1; j <= j + S[i+1].
//     Phase B: swap S[i], S[j]; ks = S[(S[i]+S[j]) mod 256].
//   DROP runs DROP_N steps and produces no output.
//   ready rises exactly 768 + 2*DROP_N cycles after the accepting start edge.
//   PRGA handshake:
//     in_ready = PRGA & phaseA & (!out_valid | out_ready).
//     An input is consumed in phase A; the matching out_data/out_last are registered at the end of phase B.
//     No PRGA step advances without an input byte, so the keystream is never skipped.
//     Sustained throughput: 1 byte per 2 cycles. Input-to-output latency: 2 cycles.
//     out_valid & !out_ready stalls the step; out_data and out_last stay stable.
//   in_last has no effect on the keystream; state stays PRGA. Re-key with a new start.
//   All index arithmetic is mod 256 (8-bit wrap); j sums use 8-bit truncation.
// STRUCTURE
//   Package rc4_pkg:
//     state encoding (IDLE, INIT, KSA, DROP, PRGA), SBOX_SIZE=256, BYTE_W=8.
//     Function key_byte(key, idx).
//   Sub-module rc4_sbox:
//     256x8 register array, no reset.
//     3 combinational read ports (S[i], S[j], S[t]).
//     1 init-write port and 1 swap port (two simultaneous writes; i==j is a no-op).
//   Core: FSM, i/j/key-index counters, DROP counter, output register.
// TESTING
//   1. key="Key" (0x4B,0x65,0x79), key_len=3, DROP_N=0, in "Plaintext"
//      -> out BB F3 16 E8 D9 40 AF 0A D3; ready 768 cycles after start.
//   2. key=01 02 03 04 05, key_len=5, in all zeros
//      -> keystream B2 39 63 05 F0 3D C0 27 (RFC 6229, offset 0).
//   3. DROP_N=4, same key as 2, in all zeros
//      -> first out F0 3D C0 27...; ready after 776 cycles.
//   4. key_len=0 and key_len=KEY_BYTES_MAX+1
//      -> err pulses 1 cycle, busy stays 0, state IDLE.
//   5. Random out_ready backpressure plus bursty in_valid over 1000 bytes
//      -> output matches the reference model exactly; out_data stable while stalled; in_last->out_last aligned.
//   6. rst asserted mid-KSA, then start with the test 1 key
//      -> all outputs 0 after the reset edge, then identical results to test 1.
//      Also: start during busy is ignored.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 stream core: state encoding, sizes and key byte selection.
package rc4_pkg;

  localparam int SBOX_SIZE = 256;
  localparam int BYTE_W    = 8;

  // Key bus wide enough for any key_len an 8-bit length field can express.
  localparam int KEY_BUS_W = 8 * 256;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INIT = 3'd1;
  localparam logic [2:0] ST_KSA  = 3'd2;
  localparam logic [2:0] ST_DROP = 3'd3;
  localparam logic [2:0] ST_PRGA = 3'd4;

  function automatic logic [BYTE_W-1:0] key_byte(input logic [KEY_BUS_W-1:0] key,
                                                 input logic [7:0]           idx);
    return key[{idx, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/rc4_sbox.sv
// 256-entry RC4 state array: three combinational reads, one init write, one swap.
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic       i_clk,
  input  logic [7:0] i_rdAddrI,
  input  logic [7:0] i_rdAddrJ,
  input  logic [7:0] i_rdAddrT,
  output logic [7:0] o_dataI,
  output logic [7:0] o_dataJ,
  output logic [7:0] o_dataT,
  input  logic       i_initEn,
  input  logic [7:0] i_initAddr,
  input  logic [7:0] i_initData,
  input  logic       i_swapEn,
  input  logic [7:0] i_swapAddrA,
  input  logic [7:0] i_swapAddrB
);

  logic [BYTE_W-1:0] r_mem [SBOX_SIZE];

  assign o_dataI = r_mem[i_rdAddrI];
  assign o_dataJ = r_mem[i_rdAddrJ];
  assign o_dataT = r_mem[i_rdAddrT];

  // Contents are only meaningful after INIT, so the array carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_initEn) begin
      r_mem[i_initAddr] <= i_initData;
    end else if (i_swapEn && (i_swapAddrA != i_swapAddrB)) begin
      r_mem[i_swapAddrA] <= r_mem[i_swapAddrB];
      r_mem[i_swapAddrB] <= r_mem[i_swapAddrA];
    end
  end

endmodule

// File: rtl/rc4_stream_core.sv
// RC4 / RC4-drop[N] stream cipher core with variable key length and valid/ready byte streams.
module rc4_stream_core
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES_MAX = 16,
  parameter int DROP_N        = 0
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [8*KEY_BYTES_MAX-1:0] key,
  input  logic [7:0]                 key_len,
  output logic                       busy,
  output logic                       ready,
  output logic                       err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_last
);

  localparam logic [7:0]  KEY_LEN_MAX = KEY_BYTES_MAX[7:0];
  localparam logic [15:0] DROP_LAST   = 16'(DROP_N - 1);
  localparam bit          DROP_EN     = (DROP_N != 0);

  logic [2:0]                 r_state;
  logic                       r_phaseB;
  logic [7:0]                 r_i;
  logic [7:0]                 r_j;
  logic [7:0]                 r_keyIdx;
  logic [7:0]                 r_keyLen;
  logic [8*KEY_BYTES_MAX-1:0] r_key;
  logic [15:0]                r_dropCnt;
  logic [7:0]                 r_inData;
  logic                       r_inLast;
  logic                       r_err;
  logic                       r_outValid;
  logic [7:0]                 r_outData;
  logic                       r_outLast;

  logic [7:0]           w_rdAddrI;
  logic [7:0]           w_si;
  logic [7:0]           w_sj;
  logic [7:0]           w_st;
  logic [7:0]           w_t;
  logic [7:0]           w_ks;
  logic [7:0]           w_keyByte;
  logic [KEY_BUS_W-1:0] w_keyBus;
  logic                 w_stepState;
  logic                 w_startAcc;
  logic                 w_keyLenOk;
  logic                 w_inFire;
  logic                 w_swapEn;
  logic                 w_initEn;

  assign w_stepState = (r_state == ST_DROP) || (r_state == ST_PRGA);
  assign w_startAcc  = start && ((r_state == ST_IDLE) || ((r_state == ST_PRGA) && !r_outValid));
  assign w_keyLenOk  = (key_len != 8'd0) && (key_len <= KEY_LEN_MAX);

  assign in_ready  = (r_state == ST_PRGA) && !r_phaseB && (!r_outValid || out_ready);
  assign w_inFire  = in_valid && in_ready;

  assign busy      = (r_state == ST_INIT) || (r_state == ST_KSA) || (r_state == ST_DROP);
  assign ready     = (r_state == ST_PRGA);
  assign err       = r_err;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_last  = r_outLast;

  // Phase A of a keystream step looks ahead at S[i+1] because i advances on that same edge.
  assign w_rdAddrI = (w_stepState && !r_phaseB) ? r_i + 8'd1 : r_i;
  assign w_t       = w_si + w_sj;
  assign w_initEn  = (r_state == ST_INIT);
  assign w_swapEn  = r_phaseB && ((r_state == ST_KSA) || w_stepState);

  // The array still holds pre-swap values in phase B, so a hit on i or j takes the swapped partner.
  assign w_ks = (w_t == r_j) ? w_si :
                (w_t == r_i) ? w_sj : w_st;

  assign w_keyBus  = {{(KEY_BUS_W - 8*KEY_BYTES_MAX){1'b0}}, r_key};
  assign w_keyByte = key_byte(w_keyBus, r_keyIdx);

  rc4_sbox u_sbox (
    .i_clk       (clk),
    .i_rdAddrI   (w_rdAddrI),
    .i_rdAddrJ   (r_j),
    .i_rdAddrT   (w_t),
    .o_dataI     (w_si),
    .o_dataJ     (w_sj),
    .o_dataT     (w_st),
    .i_initEn    (w_initEn),
    .i_initAddr  (r_i),
    .i_initData  (r_i),
    .i_swapEn    (w_swapEn),
    .i_swapAddrA (r_i),
    .i_swapAddrB (r_j)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_phaseB   <= 1'b0;
      r_i        <= 8'd0;
      r_j        <= 8'd0;
      r_keyIdx   <= 8'd0;
      r_dropCnt  <= 16'd0;
      r_err      <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= 8'd0;
      r_outLast  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
      if (w_startAcc) begin
        r_phaseB  <= 1'b0;
        r_i       <= 8'd0;
        r_j       <= 8'd0;
        r_keyIdx  <= 8'd0;
        r_dropCnt <= 16'd0;
        if (w_keyLenOk) begin
          r_state  <= ST_INIT;
          r_key    <= key;
          r_keyLen <= key_len;
        end else begin
          r_state <= ST_IDLE;
          r_err   <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_INIT: begin
            r_i <= r_i + 8'd1;
            if (r_i == 8'd255) begin
              r_state <= ST_KSA;
            end
          end
          ST_KSA: begin
            if (!r_phaseB) begin
              r_j      <= r_j + w_si + w_keyByte;
              r_phaseB <= 1'b1;
            end else begin
              r_phaseB <= 1'b0;
              r_i      <= r_i + 8'd1;
              r_keyIdx <= (r_keyIdx + 8'd1 == r_keyLen) ? 8'd0 : r_keyIdx + 8'd1;
              if (r_i == 8'd255) begin
                r_j     <= 8'd0;
                r_state <= DROP_EN ? ST_DROP : ST_PRGA;
              end
            end
          end
          ST_DROP: begin
            if (!r_phaseB) begin
              r_i      <= r_i + 8'd1;
              r_j      <= r_j + w_si;
              r_phaseB <= 1'b1;
            end else begin
              r_phaseB  <= 1'b0;
              r_dropCnt <= r_dropCnt + 16'd1;
              if (r_dropCnt == DROP_LAST) begin
                r_state <= ST_PRGA;
              end
            end
          end
          ST_PRGA: begin
            if (!r_phaseB) begin
              if (w_inFire) begin
                r_i      <= r_i + 8'd1;
                r_j      <= r_j + w_si;
                r_inData <= in_data;
                r_inLast <= in_last;
                r_phaseB <= 1'b1;
              end
            end else begin
              r_phaseB   <= 1'b0;
              r_outValid <= 1'b1;
              r_outData  <= r_inData ^ w_ks;
              r_outLast  <= r_inLast;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_stream_core.sv
// Directed and randomized checks of rc4_stream_core against known vectors and an RC4 model.
module tb_rc4_stream_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [7:0]   key_len = 8'd0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_last = 1'b0;
  logic         out_ready;

  logic       busyA, readyA, errA, inReadyA, outValidA, outLastA;
  logic [7:0] outDataA;
  logic       busyB, readyB, errB, inReadyB, outValidB, outLastB;
  logic [7:0] outDataB;

  logic       sel = 1'b0;
  logic       randReady = 1'b0;
  logic       mInReady, mOutValid, mOutLast;
  logic [7:0] mOutData;

  int         nChecks = 0;
  int         nErrors = 0;
  logic [8:0] expQ[$];

  logic [7:0] mS [256];
  logic [7:0] mI, mJ;

  logic       stalled = 1'b0;
  logic [8:0] stallV;

  localparam logic [7:0] PT  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  localparam logic [7:0] CT  [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  localparam logic [7:0] RFC [8] = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27};
  localparam logic [127:0] KEY_TXT = 128'h79654B;
  localparam logic [127:0] KEY_RFC = 128'h0504030201;

  rc4_stream_core #(.KEY_BYTES_MAX(16), .DROP_N(0)) dutA (
    .clk(clk), .rst(rst), .start(start), .key(key), .key_len(key_len),
    .busy(busyA), .ready(readyA), .err(errA),
    .in_valid(in_valid), .in_ready(inReadyA), .in_data(in_data), .in_last(in_last),
    .out_valid(outValidA), .out_ready(out_ready), .out_data(outDataA), .out_last(outLastA)
  );

  rc4_stream_core #(.KEY_BYTES_MAX(16), .DROP_N(4)) dutB (
    .clk(clk), .rst(rst), .start(start), .key(key), .key_len(key_len),
    .busy(busyB), .ready(readyB), .err(errB),
    .in_valid(in_valid), .in_ready(inReadyB), .in_data(in_data), .in_last(in_last),
    .out_valid(outValidB), .out_ready(out_ready), .out_data(outDataB), .out_last(outLastB)
  );

  assign mInReady  = sel ? inReadyB  : inReadyA;
  assign mOutValid = sel ? outValidB : outValidA;
  assign mOutData  = sel ? outDataB  : outDataA;
  assign mOutLast  = sel ? outLastB  : outLastA;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference RC4 written directly from the textbook algorithm.
  task automatic modelKey(input logic [127:0] k, input int len);
    logic [7:0] t;
    for (int c = 0; c < 256; c++) mS[c] = 8'(c);
    mJ = 8'd0;
    for (int c = 0; c < 256; c++) begin
      mJ = mJ + mS[c] + k[8*(c % len) +: 8];
      t = mS[c]; mS[c] = mS[mJ]; mS[mJ] = t;
    end
    mI = 8'd0;
    mJ = 8'd0;
  endtask

  task automatic modelByte(output logic [7:0] ks);
    logic [7:0] t;
    logic [7:0] idx;
    mI = mI + 8'd1;
    mJ = mJ + mS[mI];
    t = mS[mI]; mS[mI] = mS[mJ]; mS[mJ] = t;
    idx = mS[mI] + mS[mJ];
    ks = mS[idx];
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic startKey(input logic [127:0] k, input logic [7:0] len);
    key = k;
    key_len = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitReady(output int cyc);
    cyc = 0;
    while (cyc < 3000 && !(sel ? readyB : readyA)) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic last, input logic [7:0] exp);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (mInReady) break;
      guard++;
      if (guard > 500) begin
        checkOutput("in_ready timeout", 16'd0, 16'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    expQ.push_back({last, exp});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("drain", 16'(expQ.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  task automatic runVectorTest();
    int cyc;
    startKey(KEY_TXT, 8'd3);
    checkOutput("busy after start", 16'(busyA), 16'd1);
    waitReady(cyc);
    checkOutput("ready latency drop0", 16'(cyc), 16'd768);
    for (int n = 0; n < 9; n++) applyStimulus(PT[n], n == 8, CT[n]);
    drain();
  endtask

  // Output scoreboard and stall-stability monitor, sampled mid-cycle.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (stalled) begin
        checkOutput("stall hold", {6'd0, mOutValid, mOutLast, mOutData}, {6'd0, 1'b1, stallV});
      end
      stalled = 1'b0;
      if (!rst && mOutValid === 1'b1) begin
        if (out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected output", 16'd1, 16'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("out last/data", {7'd0, mOutLast, mOutData}, {7'd0, e});
          end
        end else begin
          stalled = 1'b1;
          stallV  = {mOutLast, mOutData};
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int len;
    logic [127:0] rk;
    logic [7:0] d;
    logic [7:0] ks;

    // Reset state
    @(posedge clk); #1;
    doReset();
    checkOutput("reset outputs",
                {2'd0, busyA, readyA, errA, inReadyA, outValidA, outLastA, outDataA}, 16'd0);

    $display("[TB] test 1: Key / Plaintext");
    runVectorTest();

    $display("[TB] test 2: RFC 6229 key 0102030405");
    doReset();
    startKey(KEY_RFC, 8'd5);
    waitReady(cyc);
    checkOutput("ready latency rfc", 16'(cyc), 16'd768);
    for (int n = 0; n < 8; n++) applyStimulus(8'h00, n == 7, RFC[n]);
    drain();

    $display("[TB] test 3: drop 4");
    sel = 1'b1;
    doReset();
    startKey(KEY_RFC, 8'd5);
    waitReady(cyc);
    checkOutput("ready latency drop4", 16'(cyc), 16'd776);
    for (int n = 0; n < 4; n++) applyStimulus(8'h00, n == 3, RFC[n+4]);
    drain();
    sel = 1'b0;

    $display("[TB] test 4: illegal key lengths");
    doReset();
    startKey(KEY_TXT, 8'd0);
    checkOutput("err len0", {14'd0, errA, busyA}, 16'b10);
    @(posedge clk); #1;
    checkOutput("err len0 one cycle", {13'd0, errA, busyA, readyA}, 16'd0);
    startKey(KEY_TXT, 8'd17);
    checkOutput("err len17", {14'd0, errA, busyA}, 16'b10);
    @(posedge clk); #1;
    checkOutput("err len17 one cycle", {13'd0, errA, busyA, readyA}, 16'd0);
    startKey(KEY_TXT, 8'd16);
    checkOutput("len16 accepted", {14'd0, errA, busyA}, 16'b01);

    $display("[TB] test 5: random stream with backpressure");
    doReset();
    len = $urandom_range(1, 16);
    rk = {$urandom, $urandom, $urandom, $urandom};
    modelKey(rk, len);
    startKey(rk, 8'(len));
    waitReady(cyc);
    checkOutput("ready latency random", 16'(cyc), 16'd768);
    randReady = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      d = 8'($urandom);
      modelByte(ks);
      applyStimulus(d, (n % 37 == 36) || (n == 999), d ^ ks);
    end
    drain();
    randReady = 1'b0;

    $display("[TB] test 6: reset mid-KSA");
    doReset();
    startKey(KEY_TXT, 8'd3);
    repeat (400) begin @(posedge clk); #1; end
    startKey(KEY_TXT, 8'd0);
    checkOutput("start ignored while busy", {14'd0, errA, busyA}, 16'b01);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("outputs after mid reset",
                {2'd0, busyA, readyA, errA, inReadyA, outValidA, outLastA, outDataA}, 16'd0);
    rst = 1'b0;
    runVectorTest();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
